// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop synchronizers, per-channel glitch filters,
// and a phase-transition decoder that drives a wrapping position counter.
module quad_decoder #(
  parameter int WIDTH      = 4,
  parameter int FILTER_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             up_down,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  localparam int MIS_W = 4;

  typedef enum logic [1:0] {
    MV_NONE,
    MV_UP,
    MV_DOWN,
    MV_ILLEGAL
  } move_e;

  // Phase vectors are {a, b}; index 1 is channel A, index 0 is channel B.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            filt_q, filt_d;
  logic [1:0]            prev_q;
  logic [1:0][MIS_W-1:0] mis_q, mis_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  ud_q, ud_d;
  logic                  step_q, step_d;
  logic                  wrap_q, wrap_d;
  logic                  err_q, err_d;
  move_e                 move;

  always_comb begin
    filt_d = filt_q;
    mis_d  = mis_q;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      if (sync2_q[ch] != filt_q[ch]) begin
        // Accept the new level on the edge where the run length reaches FILTER_LEN.
        if (mis_q[ch] == MIS_W'(FILTER_LEN - 1)) begin
          filt_d[ch] = sync2_q[ch];
          mis_d[ch]  = '0;
        end else begin
          mis_d[ch]  = mis_q[ch] + MIS_W'(1);
        end
      end else begin
        mis_d[ch] = '0;
      end
    end
  end

  always_comb begin
    move = MV_NONE;
    case ({prev_q, filt_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move = MV_UP;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: move = MV_DOWN;
      default: if ((prev_q ^ filt_q) == 2'b11) move = MV_ILLEGAL;
    endcase
  end

  always_comb begin
    count_d = count_q;
    ud_d    = ud_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = err_q;
    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (move)
        MV_UP: begin
          count_d = count_q + WIDTH'(1);
          ud_d    = 1'b1;
          step_d  = 1'b1;
          wrap_d  = (count_q == '1);
        end
        MV_DOWN: begin
          count_d = count_q - WIDTH'(1);
          ud_d    = 1'b0;
          step_d  = 1'b1;
          wrap_d  = (count_q == '0);
        end
        MV_ILLEGAL: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      mis_q   <= '0;
      count_q <= '0;
      ud_q    <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= {a, b};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      mis_q   <= mis_d;
      count_q <= count_d;
      ud_q    <= ud_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count   = count_q;
  assign up_down = ud_q;
  assign step    = step_q;
  assign wrap    = wrap_q;
  assign err     = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: expected steps are queued by the stimulus
// and consumed by a monitor whenever the DUT pulses step.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a   = 1'b0;
  logic       b   = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] count;
  logic       up_down, step, wrap, err;

  typedef struct packed {
    logic [3:0] cnt;
    logic       ud;
    logic       wr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  quad_decoder #(.WIDTH(4), .FILTER_LEN(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .clr    (clr),
    .count  (count),
    .up_down(up_down),
    .step   (step),
    .wrap   (wrap),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && step) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("step_count", int'(count), int'(e.cnt));
        check("step_updown", int'(up_down), int'(e.ud));
        check("step_wrap", int'(wrap), int'(e.wr));
      end
    end
  end

  // Drive phase {a,b} at a falling edge, hold for 'hold' cycles, report the
  // rising edge (1-based) on which step was first seen, or -1.
  task automatic apply(input logic [1:0] ph, input int hold, output int lat);
    @(negedge clk);
    {a, b} = ph;
    lat = -1;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      #1;
      if (step && lat < 0) lat = i;
    end
  endtask

  task automatic push(input logic [3:0] c, input logic ud, input logic wr);
    exp_t e;
    e.cnt = c;
    e.ud  = ud;
    e.wr  = wr;
    exp_q.push_back(e);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int lat;
    #12;
    check("rst_count", int'(count), 0);
    check("rst_flags", int'({up_down, step, wrap, err}), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Four up phases; first step must land on edge 5 after the change.
    push(4'd1, 1'b1, 1'b0);
    apply(2'b10, 10, lat);
    check("latency", lat, 5);
    push(4'd2, 1'b1, 1'b0); apply(2'b11, 10, lat);
    push(4'd3, 1'b1, 1'b0); apply(2'b01, 10, lat);
    push(4'd4, 1'b1, 1'b0); apply(2'b00, 10, lat);
    check("up4_count", int'(count), 4);
    check("up4_updown", int'(up_down), 1);

    // Down from zero wraps to 15.
    pulse_clr();
    #1;
    check("clr_count", int'(count), 0);
    push(4'd15, 1'b0, 1'b1);
    apply(2'b01, 10, lat);
    check("down_count", int'(count), 15);
    check("down_updown", int'(up_down), 0);

    // One-cycle glitch on a is filtered out.
    @(negedge clk); a = 1'b1;
    @(negedge clk); a = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_count", int'(count), 15);
    check("glitch_err", int'(err), 0);

    // Up wraps 15 -> 0, then one more up step.
    push(4'd0, 1'b1, 1'b1); apply(2'b00, 10, lat);
    push(4'd1, 1'b1, 1'b0); apply(2'b10, 10, lat);

    // Both bits change together: error, no count change.
    apply(2'b01, 10, lat);
    check("illegal_err", int'(err), 1);
    check("illegal_count", int'(count), 1);
    check("illegal_updown", int'(up_down), 1);
    repeat (10) @(negedge clk);
    check("illegal_sticky", int'(err), 1);
    pulse_clr();
    #1;
    check("clr_err", int'(err), 0);
    check("clr_count2", int'(count), 0);

    // Down step 01 -> 11 decodes on the same edge clr is high: discarded.
    @(negedge clk);
    {a, b} = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      clr = (i == 4);
    end
    check("clrstep_count", int'(count), 0);
    check("clrstep_updown", int'(up_down), 1);
    push(4'd1, 1'b1, 1'b0); apply(2'b01, 10, lat);
    check("after_clr_count", int'(count), 1);

    // Climb to 7, then reset asynchronously between edges.
    push(4'd2, 1'b1, 1'b0); apply(2'b00, 10, lat);
    push(4'd3, 1'b1, 1'b0); apply(2'b10, 10, lat);
    push(4'd4, 1'b1, 1'b0); apply(2'b11, 10, lat);
    push(4'd5, 1'b1, 1'b0); apply(2'b01, 10, lat);
    push(4'd6, 1'b1, 1'b0); apply(2'b00, 10, lat);
    push(4'd7, 1'b1, 1'b0); apply(2'b10, 10, lat);
    check("pre_rst_count", int'(count), 7);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_flags", int'({up_down, step, wrap, err}), 0);
    {a, b} = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_count", int'(count), 0);
    check("post_rst_err", int'(err), 0);
    push(4'd1, 1'b1, 1'b0); apply(2'b10, 10, lat);
    check("post_rst_step", int'(count), 1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, position counter width in bits.
REQ-002 SHALL have parameter FILTER_LEN, default 2, consecutive stable samples required to accept a phase change (range 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port a  input  1  encoder phase A, asynchronous to clk.
REQ-006 SHALL have port b  input  1  encoder phase B, asynchronous to clk.
REQ-007 SHALL have port clr  input  1  synchronous clear of count and err.
REQ-008 SHALL have port count  output  WIDTH  decoded position.
REQ-009 SHALL have port up_down  output  1  direction of the last valid step (1 = up, 0 = down).
REQ-010 SHALL have port step  output  1  one-cycle pulse per accepted valid step.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse when count wraps in either direction.
REQ-012 SHALL have port err  output  1  sticky illegal-transition flag.

Function
REQ-013 SHALL pass a and b each through a 2-flop synchronizer.
REQ-014 SHALL run an independent glitch filter per channel: a mismatch counter increments on each edge where the synchronized value differs from the filtered value and resets to 0 on any edge where they match.
REQ-015 SHALL update a filtered bit on the edge where its mismatch counter reaches FILTER_LEN; the mismatch counter then returns to 0.
REQ-016 SHALL hold the previous filtered phase {a_f,b_f} and compare it with the current filtered phase every cycle.
REQ-017 SHALL treat the up sequence as 00->10->11->01->00 (A leads B); the down sequence is its reverse.
REQ-018 SHALL, on an up transition, increment count by 1 modulo 2^WIDTH, set up_down=1 and pulse step.
REQ-019 SHALL, on a down transition, decrement count by 1 modulo 2^WIDTH, set up_down=0 and pulse step.
REQ-020 SHALL pulse wrap in the same cycle as step when count goes from 2^WIDTH-1 to 0, or from 0 to 2^WIDTH-1.
REQ-021 SHALL, on a transition where both filtered bits change on the same edge, set err=1, leave count and up_down unchanged, not pulse step, and adopt the new phase as the previous phase.
REQ-022 SHALL leave up_down unchanged when no step occurs.
REQ-023 SHALL have a latency of FILTER_LEN+3 rising edges from the first edge sampling a stable input change to count/step updating; with the default this is edge 5.
REQ-024 SHALL, when clr=1 on an edge: set count=0 and err=0, force step=0 and wrap=0, retain filtered/previous phase and up_down, and discard any step decoded on that edge.
REQ-025 SHALL accept at most one step per clock; steady inputs SHALL produce no step.

Reset
REQ-026 SHALL, while rst=0, asynchronously force all of the following to 0: synchronizers, filtered bits, previous phase, mismatch counters, count, up_down, step, wrap and err.
REQ-027 SHALL resume decoding from baseline phase 00 on the first edge after rst deasserts.
REQ-028 SHALL, if inputs are 11 at reset release and both filters settle on the same edge, set err=1 (documented behaviour).
REQ-029 SHALL, on reset asserted mid-step, leave no pending filter or step state after release.

Verification
REQ-030 SHALL cover: reset release with a=b=0, then four up phases each held 10 cycles -> count 0->4, four step pulses, up_down=1, first update on edge 5 after the change.
REQ-031 SHALL cover: from count=0, one down phase (00->01) -> count=15, wrap=1 and step=1 in the same cycle, up_down=0.
REQ-032 SHALL cover: a 1-cycle glitch on a (FILTER_LEN=2) -> no step, count unchanged, err=0.
REQ-033 SHALL cover: a and b toggled together 00->11 -> err=1 and stays 1, count unchanged; a following clr pulse -> err=0, count=0.
REQ-034 SHALL cover: clr asserted on the same edge a valid step decodes -> count=0, step=0, and the next valid up step gives count=1.
REQ-035 SHALL cover: rst pulsed low mid-sequence at count=7 -> all outputs 0 immediately, without waiting for a clock edge.
